// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared types for the multicycle control sequencer:
//   state_t        sequencer states
//   instr_class_t  Opcode[7:6] instruction class
//   ctrl_func_t    Opcode[5:3] meaning for the control class
//   cond_t         Opcode[2:0] branch condition codes
//   INT_VECTOR     address loaded into Pc when the datapath selects PC_INT
// plus the datapath select encodings that the sequencer drives (ALU op,
// Pc / Op1 / Op2 / Imm / Wd / Rs1 / Lr / Rw selects).
// ----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH_A = 3'd0,
    S_FETCH_D = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM_A   = 3'd3,
    S_MEM_D   = 3'd4,
    S_INT     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU_REG = 2'b00,
    CLS_ALU_IMM = 2'b01,
    CLS_MEM     = 2'b10,
    CLS_CTRL    = 2'b11
  } instr_class_t;

  // Codes 101..111 are not listed; they decode as NOP.
  typedef enum logic [2:0] {
    CF_B    = 3'b000,
    CF_BL   = 3'b001,
    CF_RET  = 3'b010,
    CF_NOP  = 3'b011,
    CF_RETI = 3'b100
  } ctrl_func_t;

  typedef enum logic [2:0] {
    CC_AL = 3'b000,  // always
    CC_EQ = 3'b001,  // Z
    CC_NE = 3'b010,  // !Z
    CC_CS = 3'b011,  // C
    CC_CC = 3'b100,  // !C
    CC_MI = 3'b101,  // N
    CC_PL = 3'b110,  // !N
    CC_NV = 3'b111   // never
  } cond_t;

  localparam logic [15:0] INT_VECTOR = 16'h0010;

  // Datapath select encodings. ALU ops 0..7 are indexed directly by func.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SHL   = 4'd5,
    ALU_SHR   = 4'd6,
    ALU_ADC   = 4'd7,
    ALU_PASS1 = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {PC_1 = 2'd0, PC_ALU_OUT = 2'd1, PC_LR = 2'd2, PC_INT = 2'd3} pc_sel_t;
  typedef enum logic {OP1_RD1 = 1'b0, OP1_PC = 1'b1} op1_sel_t;
  typedef enum logic {OP2_RD2 = 1'b0, OP2_IMM = 1'b1} op2_sel_t;
  typedef enum logic {IMM_SHORT = 1'b0, IMM_LONG = 1'b1} imm_sel_t;
  typedef enum logic {WD_ALU = 1'b0, WD_SYS = 1'b1} wd_sel_t;
  typedef enum logic {RS1_RA = 1'b0, RS1_RD = 1'b1} rs1_sel_t;
  typedef enum logic {LR_ALU = 1'b0, LR_SYS = 1'b1} lr_sel_t;
  typedef enum logic {RW_RD = 1'b0, RW_LR = 1'b1} rw_sel_t;

endpackage

// File: rtl/control_sequencer_cond_eval.sv
// ----------------------------------------------------------------------------
// cond_eval
// Combinational branch-condition evaluator.
// Ports:
//   flags  in  4  flag register {N,Z,V,C}
//   cc     in     condition code (cond_t)
//   take   out 1  1 when the branch condition holds
// ----------------------------------------------------------------------------
module cond_eval
  import seq_pkg::*;
(
  input  logic [3:0] flags,
  input  cond_t      cc,
  output logic       take
);

  always_comb begin
    take = 1'b0;
    unique case (cc)
      CC_AL:   take = 1'b1;
      CC_EQ:   take = flags[2];
      CC_NE:   take = ~flags[2];
      CC_CS:   take = flags[0];
      CC_CC:   take = ~flags[0];
      CC_MI:   take = flags[3];
      CC_PL:   take = ~flags[3];
      CC_NV:   take = 1'b0;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
// Multicycle control FSM for the CPU datapath: fetch, decode/execute, memory
// access and writeback over the multiplexed SysBus (address phase followed by
// a data phase that stretches until MemRdy). Holds the {N,Z,V,C} flag register.
//
// Parameters:
//   RESET_STATE  state entered while nReset is low (default S_FETCH_A)
//   MAX_WAIT     data-phase timeout in cycles, 0 = no timeout
//
// Ports:
//   Clock, nReset         clock (rising edge), async active-low reset
//   Irq                   level interrupt request (SEQ_IRQ_EN builds only)
//   Opcode[7:0]           Ir[15:8]: class[7:6], func[5:3], cc[2:0]
//   Flags[3:0]            combinational ALU flags {N,Z,V,C}
//   MemRdy                memory completes the data phase this cycle
//   Ale, RnW              SysBus address phase / read-not-write
//   BusErr                sticky data-phase timeout flag
//   AluOp..RwSel          datapath selects
//   AluEn..MemEn          datapath strobes (PcEn/LrEn/AluEn/MemEn mutually
//                         exclusive)
//   CFlag                 registered carry for the ALU CarryIn
//
// Build option: define SEQ_IRQ_EN to add the Irq input, the IE bit and the
// S_INT vectoring state. Without it RETI behaves exactly like RET.
// ----------------------------------------------------------------------------
module control_sequencer
  import seq_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH_A,
  parameter int     MAX_WAIT    = 0
) (
  input  logic       Clock,
  input  logic       nReset,
`ifdef SEQ_IRQ_EN
  input  logic       Irq,
`endif
  input  logic [7:0] Opcode,
  input  logic [3:0] Flags,
  input  logic       MemRdy,
  output logic       Ale,
  output logic       RnW,
  output logic       BusErr,
  output alu_op_t    AluOp,
  output pc_sel_t    PcSel,
  output op1_sel_t   Op1Sel,
  output op2_sel_t   Op2Sel,
  output imm_sel_t   ImmSel,
  output wd_sel_t    WdSel,
  output rs1_sel_t   Rs1Sel,
  output lr_sel_t    LrSel,
  output rw_sel_t    RwSel,
  output logic       AluEn,
  output logic       AluWe,
  output logic       LrEn,
  output logic       LrWe,
  output logic       PcEn,
  output logic       PcWe,
  output logic       IrWe,
  output logic       RegWe,
  output logic       MemEn,
  output logic       CFlag
);

  localparam logic [15:0] WAIT_LAST = (MAX_WAIT > 0) ? 16'(MAX_WAIT - 1) : 16'd0;

  state_t       state_reg, state_next;
  logic [3:0]   flags_reg;
  logic         bus_err_reg;
  logic [15:0]  wait_cnt_reg;

  instr_class_t cls;
  ctrl_func_t   cfunc;
  logic [2:0]   func;
  logic         is_stw;
  logic         take;
  logic         in_data;
  logic         timeout;

  assign cls    = instr_class_t'(Opcode[7:6]);
  assign func   = Opcode[5:3];
  assign cfunc  = ctrl_func_t'(Opcode[5:3]);
  assign is_stw = Opcode[3];

  cond_eval u_cond_eval (
    .flags (flags_reg),
    .cc    (cond_t'(Opcode[2:0])),
    .take  (take)
  );

  // The counter holds the number of wait cycles already spent in the current
  // data phase, so the timeout fires on the MAX_WAIT-th consecutive wait cycle.
  assign in_data = (state_reg == S_FETCH_D) || (state_reg == S_MEM_D);
  assign timeout = (MAX_WAIT > 0) && in_data && !MemRdy && (wait_cnt_reg == WAIT_LAST);

  assign BusErr = bus_err_reg;
  assign CFlag  = flags_reg[0];

`ifdef SEQ_IRQ_EN
  logic ie_reg;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      ie_reg <= 1'b1;
    end else if (state_reg == S_INT) begin
      ie_reg <= 1'b0;
    end else if (state_reg == S_EXEC && cls == CLS_CTRL && cfunc == CF_RETI) begin
      ie_reg <= 1'b1;
    end
  end
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg    <= RESET_STATE;
      flags_reg    <= 4'd0;
      bus_err_reg  <= 1'b0;
      wait_cnt_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_EXEC && (cls == CLS_ALU_REG || cls == CLS_ALU_IMM)) begin
        flags_reg <= Flags;
      end
      if (timeout) begin
        bus_err_reg <= 1'b1;
      end
      if (in_data && !MemRdy && !timeout) begin
        wait_cnt_reg <= wait_cnt_reg + 16'd1;
      end else begin
        wait_cnt_reg <= 16'd0;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    Ale    = 1'b0;
    RnW    = 1'b1;
    AluEn  = 1'b0;
    AluWe  = 1'b0;
    LrEn   = 1'b0;
    LrWe   = 1'b0;
    PcEn   = 1'b0;
    PcWe   = 1'b0;
    IrWe   = 1'b0;
    RegWe  = 1'b0;
    MemEn  = 1'b0;
    AluOp  = ALU_ADD;
    PcSel  = PC_1;
    Op1Sel = OP1_RD1;
    Op2Sel = OP2_RD2;
    ImmSel = IMM_SHORT;
    WdSel  = WD_ALU;
    Rs1Sel = RS1_RA;
    LrSel  = LR_ALU;
    RwSel  = RW_RD;

    // Outputs are decoded from state, so they are masked while nReset is low
    // to keep every strobe and Ale inactive throughout reset.
    if (nReset) begin
      unique case (state_reg)
        S_FETCH_A: begin
          PcEn       = 1'b1;
          Ale        = 1'b1;
          state_next = S_FETCH_D;
        end
        S_FETCH_D: begin
          MemEn = 1'b1;
          if (MemRdy) begin
            IrWe       = 1'b1;
            PcSel      = PC_1;
            PcWe       = 1'b1;
            state_next = S_EXEC;
          end else if (timeout) begin
            state_next = S_FETCH_A;
          end
        end
        S_EXEC: begin
          unique case (cls)
            CLS_ALU_REG, CLS_ALU_IMM: begin
              Rs1Sel     = RS1_RA;
              Op1Sel     = OP1_RD1;
              Op2Sel     = (cls == CLS_ALU_REG) ? OP2_RD2 : OP2_IMM;
              ImmSel     = IMM_SHORT;
              AluOp      = alu_op_t'({1'b0, func});
              WdSel      = WD_ALU;
              RwSel      = RW_RD;
              RegWe      = 1'b1;
              state_next = S_FETCH_A;
            end
            CLS_MEM: begin
              // Effective address Rd1(Ra) + short immediate lands in AluOut.
              Rs1Sel     = RS1_RA;
              Op1Sel     = OP1_RD1;
              Op2Sel     = OP2_IMM;
              ImmSel     = IMM_SHORT;
              AluOp      = ALU_ADD;
              AluWe      = 1'b1;
              state_next = S_MEM_A;
            end
            default: begin
              // Branch target = already-incremented Pc + long immediate.
              Op1Sel     = OP1_PC;
              Op2Sel     = OP2_IMM;
              ImmSel     = IMM_LONG;
              AluOp      = ALU_ADD;
              state_next = S_FETCH_A;
              unique case (cfunc)
                CF_B: begin
                  if (take) begin
                    PcSel = PC_ALU_OUT;
                    PcWe  = 1'b1;
                  end
                end
                CF_BL: begin
                  // Pc drives SysBus so Lr captures the return address while
                  // Pc loads the target at the same edge.
                  PcEn  = 1'b1;
                  LrSel = LR_SYS;
                  LrWe  = 1'b1;
                  PcSel = PC_ALU_OUT;
                  PcWe  = 1'b1;
                end
                CF_RET, CF_RETI: begin
                  PcSel = PC_LR;
                  PcWe  = 1'b1;
                end
                default: ;
              endcase
            end
          endcase
        end
        S_MEM_A: begin
          AluEn = 1'b1;
          Ale   = 1'b1;
          RnW   = ~is_stw;
          if (is_stw) begin
            // Address is on the bus; swap AluOut to the store data for the
            // data phase.
            Rs1Sel = RS1_RD;
            AluOp  = ALU_PASS1;
            AluWe  = 1'b1;
          end
          state_next = S_MEM_D;
        end
        S_MEM_D: begin
          if (is_stw) begin
            AluEn = 1'b1;
            RnW   = 1'b0;
          end else begin
            MemEn = 1'b1;
            WdSel = WD_SYS;
            RwSel = RW_RD;
            RegWe = MemRdy;
          end
          if (MemRdy || timeout) begin
            state_next = S_FETCH_A;
          end
        end
        S_INT: begin
          PcEn       = 1'b1;
          LrSel      = LR_SYS;
          LrWe       = 1'b1;
          PcSel      = PC_INT;
          PcWe       = 1'b1;
          state_next = S_FETCH_A;
        end
        default: state_next = S_FETCH_A;
      endcase

`ifdef SEQ_IRQ_EN
      // Instruction boundary: divert to the interrupt entry state instead.
      if (state_next == S_FETCH_A && state_reg != S_INT && Irq && ie_reg) begin
        state_next = S_INT;
      end
`endif
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
// Self-checking bench for control_sequencer (MAX_WAIT = 4). Each instruction
// is walked cycle by cycle; the expected strobe set of every cycle comes from
// the instruction's phase timeline and a model of the flag register.
// ----------------------------------------------------------------------------
module tb_control_sequencer;
  import seq_pkg::*;

  logic       Clock = 1'b0;
  logic       nReset = 1'b0;
  logic [7:0] Opcode = 8'd0;
  logic [3:0] Flags = 4'd0;
  logic       MemRdy = 1'b0;
`ifdef SEQ_IRQ_EN
  logic       Irq = 1'b0;
`endif
  logic       Ale, RnW, BusErr, CFlag;
  alu_op_t    AluOp;
  pc_sel_t    PcSel;
  op1_sel_t   Op1Sel;
  op2_sel_t   Op2Sel;
  imm_sel_t   ImmSel;
  wd_sel_t    WdSel;
  rs1_sel_t   Rs1Sel;
  lr_sel_t    LrSel;
  rw_sel_t    RwSel;
  logic       AluEn, AluWe, LrEn, LrWe, PcEn, PcWe, IrWe, RegWe, MemEn;

  control_sequencer #(.MAX_WAIT(4)) dut (
    .Clock (Clock), .nReset (nReset),
`ifdef SEQ_IRQ_EN
    .Irq (Irq),
`endif
    .Opcode (Opcode), .Flags (Flags), .MemRdy (MemRdy),
    .Ale (Ale), .RnW (RnW), .BusErr (BusErr),
    .AluOp (AluOp), .PcSel (PcSel), .Op1Sel (Op1Sel), .Op2Sel (Op2Sel),
    .ImmSel (ImmSel), .WdSel (WdSel), .Rs1Sel (Rs1Sel), .LrSel (LrSel),
    .RwSel (RwSel), .AluEn (AluEn), .AluWe (AluWe), .LrEn (LrEn),
    .LrWe (LrWe), .PcEn (PcEn), .PcWe (PcWe), .IrWe (IrWe),
    .RegWe (RegWe), .MemEn (MemEn), .CFlag (CFlag)
  );

  always #5 Clock = ~Clock;

  // Strobe vector bit positions.
  localparam logic [10:0] PCEN  = 11'h400, LREN = 11'h200, ALUEN = 11'h100,
                          MEMEN = 11'h080, ALUWE = 11'h040, LRWE = 11'h020,
                          PCWE  = 11'h010, IRWE = 11'h008, REGWE = 11'h004,
                          ALE   = 11'h002, RNW = 11'h001;

  logic [10:0] obs;
  assign obs = {PcEn, LrEn, AluEn, MemEn, AluWe, LrWe, PcWe, IrWe, RegWe, Ale, RnW};

  int tests = 0;
  int fails = 0;
  logic [3:0] flags_m = 4'd0;  // model of the architectural flag register

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait to the falling edge and compare the strobe set of this cycle.
  task automatic expect_obs(input string tag, input logic [10:0] exp);
    @(negedge Clock);
    chk(tag, 32'(obs), 32'(exp));
    chk({tag, "_excl"}, 32'($countones({PcEn, LrEn, AluEn, MemEn}) <= 1), 32'd1);
  endtask

  task automatic adv();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic cond_ok(input logic [3:0] f, input logic [2:0] cc);
    logic n, z, c;
    n = f[3]; z = f[2]; c = f[0];
    case (cc)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return c;
      3'd4: return !c;
      3'd5: return n;
      3'd6: return !n;
      default: return 1'b0;
    endcase
  endfunction

  // One full instruction starting in the fetch address phase; wf / wm are the
  // wait cycles in the fetch and memory data phases.
  task automatic run_instr(input logic [7:0] op, input logic [3:0] fl, input int wf, input int wm);
    logic [1:0]  cls;
    logic [2:0]  fn, cc;
    logic        stw, take;
    logic [10:0] e;
    cls = op[7:6]; fn = op[5:3]; cc = op[2:0]; stw = op[3];
    Opcode = op; Flags = fl; MemRdy = 1'b0;
    expect_obs("fetch_a", PCEN | ALE | RNW);
    adv();
    for (int i = 0; i <= wf; i++) begin
      MemRdy = (i == wf);
      expect_obs("fetch_d", MEMEN | RNW | ((i == wf) ? (IRWE | PCWE) : 11'h0));
      if (i == wf) chk("fetch_pcsel", 32'(PcSel), 32'(PC_1));
      adv();
    end
    MemRdy = 1'b0;
    if (cls[1] == 1'b0) begin
      expect_obs("exec_alu", REGWE | RNW);
      chk("alu_op", 32'(AluOp), 32'({1'b0, fn}));
      chk("alu_wdsel", 32'(WdSel), 32'(WD_ALU));
      chk("alu_op2sel", 32'(Op2Sel), 32'((cls == 2'b00) ? OP2_RD2 : OP2_IMM));
      adv();
      flags_m = fl;
    end else if (cls == 2'b10) begin
      expect_obs("exec_mem", ALUWE | RNW);
      chk("mem_addr_op", 32'(AluOp), 32'(ALU_ADD));
      adv();
      expect_obs(stw ? "mem_a_stw" : "mem_a_ldw", ALUEN | ALE | (stw ? ALUWE : RNW));
      if (stw) chk("stw_pass1", 32'(AluOp), 32'(ALU_PASS1));
      adv();
      for (int i = 0; i <= wm; i++) begin
        MemRdy = (i == wm);
        if (stw) begin
          expect_obs("mem_d_stw", ALUEN);
        end else begin
          expect_obs("mem_d_ldw", MEMEN | RNW | ((i == wm) ? REGWE : 11'h0));
          chk("ldw_wdsel", 32'(WdSel), 32'(WD_SYS));
        end
        adv();
      end
      MemRdy = 1'b0;
    end else begin
      take = cond_ok(flags_m, cc);
      case (fn)
        3'd0:       e = RNW | (take ? PCWE : 11'h0);
        3'd1:       e = PCEN | LRWE | PCWE | RNW;
        3'd2, 3'd4: e = PCWE | RNW;
        default:    e = RNW;
      endcase
      expect_obs("exec_ctrl", e);
      if ((fn == 3'd0 && take) || fn == 3'd1) chk("branch_pcsel", 32'(PcSel), 32'(PC_ALU_OUT));
      if (fn == 3'd2 || fn == 3'd4) chk("ret_pcsel", 32'(PcSel), 32'(PC_LR));
      adv();
    end
    chk("cflag", 32'(CFlag), 32'(flags_m[0]));
  endtask

  // From the checked fetch address phase, run an LDW into its data phase.
  task automatic ldw_to_mem_d();
    adv();
    MemRdy = 1'b1;
    expect_obs("p_fetch_d", MEMEN | RNW | IRWE | PCWE);
    adv();
    MemRdy = 1'b0;
    expect_obs("p_exec", ALUWE | RNW);
    adv();
    expect_obs("p_mem_a", ALUEN | ALE | RNW);
    adv();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk("rst_strobes", 32'(obs), 32'(RNW));
    chk("rst_buserr", 32'(BusErr), 32'd0);
    chk("rst_cflag", 32'(CFlag), 32'd0);
    chk("rst_pcsel", 32'(PcSel), 32'(PC_1));
    adv();
    nReset = 1'b1;

    // Directed instructions
    run_instr(8'b00_000_000, 4'h0, 0, 0);   // ADD reg, zero wait
    run_instr(8'b10_000_000, 4'h0, 0, 2);   // LDW, 2 wait cycles
    run_instr(8'b10_001_000, 4'h0, 1, 1);   // STW
    run_instr(8'b01_010_000, 4'b0100, 0, 0); // ALU imm, Z=1
    run_instr(8'b11_000_001, 4'h0, 0, 0);   // B EQ taken
    run_instr(8'b00_001_000, 4'b0001, 0, 0); // ALU, Z=0 C=1
    run_instr(8'b11_000_001, 4'h0, 0, 0);   // B EQ not taken
    run_instr(8'b11_000_111, 4'h0, 0, 0);   // B never
    run_instr(8'b11_001_000, 4'h0, 0, 0);   // BL
    run_instr(8'b11_010_000, 4'h0, 0, 0);   // RET

`ifdef SEQ_IRQ_EN
    Irq = 1'b1;
    run_instr(8'b00_011_000, 4'h0, 0, 0);
    expect_obs("int_entry", PCEN | LRWE | PCWE | RNW);
    chk("int_pcsel", 32'(PcSel), 32'(PC_INT));
    chk("int_lrsel", 32'(LrSel), 32'(LR_SYS));
    adv();
    run_instr(8'b00_100_000, 4'h0, 0, 0);   // IE clear: no second entry
    run_instr(8'b11_100_000, 4'h0, 0, 0);   // RETI re-enables
    expect_obs("int_reentry", PCEN | LRWE | PCWE | RNW);
    chk("int_reentry_pcsel", 32'(PcSel), 32'(PC_INT));
    adv();
    Irq = 1'b0;
`endif

    // Randomized instruction stream (waits stay below the timeout)
    for (int n = 0; n < 40; n++) begin
      run_instr(8'($urandom), 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Carry set, then an LDW whose data phase never completes
    run_instr(8'b00_000_000, 4'b0001, 0, 0);
    Opcode = 8'b10_000_000;
    expect_obs("to_fetch_a", PCEN | ALE | RNW);
    ldw_to_mem_d();
    for (int i = 0; i < 4; i++) begin
      expect_obs("to_wait", MEMEN | RNW);
      chk("to_buserr_low", 32'(BusErr), 32'd0);
      adv();
    end
    expect_obs("to_refetch", PCEN | ALE | RNW);
    chk("to_buserr_set", 32'(BusErr), 32'd1);
    chk("to_cflag", 32'(CFlag), 32'd1);

    // Reset in the middle of an LDW data phase
    ldw_to_mem_d();
    #3;
    nReset = 1'b0;
    #1;
    chk("mid_rst_strobes", 32'(obs), 32'(RNW));
    chk("mid_rst_cflag", 32'(CFlag), 32'd0);
    chk("mid_rst_buserr", 32'(BusErr), 32'd0);
    flags_m = 4'd0;
    adv();
    nReset = 1'b1;
    expect_obs("post_rst_fetch_a", PCEN | ALE | RNW);
    adv();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
